// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the EX-stage issue logic and the multiply/divide unit.
// The master issues MULT/DIV/MTHI/MTLO requests; the slave returns busy/done and HI/LO.
interface mult_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [5:0]      funct;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, funct, operand1, operand2,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, funct, operand1, operand2,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit holding the HI/LO registers.
// Optional build macro MDU_EARLY_OUT_EN: zero-operand multiplies and zero-divisor divides finish at accept.
//
// state | meaning
// IDLE  | waiting for a request; MTHI/MTLO complete here
// RUN   | one shift-add / restoring shift-subtract step per cycle
// FIX   | sign correction, HI/LO write, done pulse next cycle
module mult_div_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input logic            clk,
  input logic            reset_n,
  mult_div_unit_if.slave mdu
);

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam int         CW      = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state;
  logic [XLEN-1:0]   hi_r, lo_r;
  logic [XLEN-1:0]   operand_b;
  logic [XLEN-1:0]   dividend_raw;
  logic [2*XLEN-1:0] work;
  logic [CW-1:0]     count;
  logic              is_div, res_neg, rem_neg, div_zero;
  logic              busy_r, done_r;

  logic              acc_signed, early;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     add_sum, partial, diff;
  logic              fits;
  logic [XLEN-1:0]   res_hi, res_lo;
  logic [2*XLEN-1:0] prod_fix;

  // Magnitudes of 0x80000000 stay 0x80000000, read as unsigned downstream.
  always_comb begin
    acc_signed = (mdu.funct == F_MULT) || (mdu.funct == F_DIV);
    abs_a = (acc_signed && mdu.operand1[XLEN-1]) ? -mdu.operand1 : mdu.operand1;
    abs_b = (acc_signed && mdu.operand2[XLEN-1]) ? -mdu.operand2 : mdu.operand2;
  end

`ifdef MDU_EARLY_OUT_EN
  assign early = mdu.funct[1] ? (mdu.operand2 == '0)
                              : ((mdu.operand1 == '0) || (mdu.operand2 == '0));
`else
  assign early = 1'b0;
`endif

  always_comb begin
    add_sum = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, operand_b} : '0);
    partial = work[2*XLEN-1:XLEN-1];
    diff    = partial - {1'b0, operand_b};
    fits    = partial >= {1'b0, operand_b};
  end

  always_comb begin
    prod_fix = res_neg ? -work : work;
    res_hi   = prod_fix[2*XLEN-1:XLEN];
    res_lo   = prod_fix[XLEN-1:0];
    if (div_zero) begin
      res_hi = dividend_raw;
      res_lo = '1;
    end else if (is_div) begin
      res_lo = res_neg ? -work[XLEN-1:0] : work[XLEN-1:0];
      res_hi = rem_neg ? -work[2*XLEN-1:XLEN] : work[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      hi_r         <= '0;
      lo_r         <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      operand_b    <= '0;
      dividend_raw <= '0;
      work         <= '0;
      count        <= '0;
      is_div       <= 1'b0;
      res_neg      <= 1'b0;
      rem_neg      <= 1'b0;
      div_zero     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (mdu.start) begin
            case (mdu.funct)
              F_MTHI: begin
                hi_r   <= mdu.operand1;
                done_r <= 1'b1;
              end
              F_MTLO: begin
                lo_r   <= mdu.operand1;
                done_r <= 1'b1;
              end
              F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                if (early) begin
                  hi_r   <= mdu.funct[1] ? mdu.operand1 : '0;
                  lo_r   <= mdu.funct[1] ? '1 : '0;
                  done_r <= 1'b1;
                end else begin
                  // Divides shift the dividend through work; multiplies shift the multiplier.
                  operand_b    <= mdu.funct[1] ? abs_b : abs_a;
                  work         <= {{XLEN{1'b0}}, (mdu.funct[1] ? abs_a : abs_b)};
                  is_div       <= mdu.funct[1];
                  res_neg      <= acc_signed && (mdu.operand1[XLEN-1] ^ mdu.operand2[XLEN-1]);
                  rem_neg      <= acc_signed && mdu.operand1[XLEN-1];
                  div_zero     <= mdu.funct[1] && (mdu.operand2 == '0);
                  dividend_raw <= mdu.operand1;
                  count        <= '0;
                  busy_r       <= 1'b1;
                  state        <= RUN;
                end
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (is_div) begin
            work <= fits ? {diff[XLEN-1:0], work[XLEN-2:0], 1'b1}
                         : {partial[XLEN-1:0], work[XLEN-2:0], 1'b0};
          end else begin
            work <= {add_sum, work[XLEN-1:1]};
          end
          count <= count + 1'b1;
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          hi_r   <= res_hi;
          lo_r   <= res_lo;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mdu.busy = busy_r;
  assign mdu.done = done_r;
  assign mdu.hi   = hi_r;
  assign mdu.lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes expected HI/LO and latency, monitor pops on done.
// Define MDU_EARLY_OUT_EN for both RTL and bench to exercise the early-out build.
module tb_mult_div_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if #(.XLEN(XLEN)) bus ();

  mult_div_unit #(.XLEN(XLEN), .ITER(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mdu     (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          busy_run = 0;
  int          done_seen = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model: architectural results straight from MIPS arithmetic rules.
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    logic [63:0] p;
    longint q, r;
    lat = 34;
    case (f)
      6'h18: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      6'h19: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      6'h1A, 6'h1B: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a;
        end else if (f == 6'h1A) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      6'h11: begin m_hi = a; lat = 1; end
      6'h13: begin m_lo = a; lat = 1; end
      default: lat = 0;
    endcase
`ifdef MDU_EARLY_OUT_EN
    if ((f == 6'h18 || f == 6'h19) && (a == 0 || b == 0)) lat = 1;
    if ((f == 6'h1A || f == 6'h1B) && b == 0) lat = 1;
`endif
  endtask

  task automatic wait_idle(input int bound);
    int w = 0;
    while (bus.busy !== 1'b0 && w < bound) begin
      @(posedge clk); #1; w++;
    end
    if (w >= bound) begin
      total++; bad++;
      $display("FAIL wait_idle: busy still high after %0d cycles", w);
    end
  endtask

  // Called just after a rising edge; the request is taken at the next edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int lat;
    wait_idle(100);
    bus.start = 1'b1; bus.funct = f; bus.operand1 = a; bus.operand2 = b;
    model(f, a, b, lat);
    e.hi = m_hi; e.lo = m_lo; e.lat = lat; e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || bus.busy !== 1'b0) && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 200) begin
      total++; bad++;
      $display("FAIL drain: %0d results still pending after %0d cycles", sb.size(), w);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        busy_run = 0;
      end else begin
        if (bus.busy === 1'b1) busy_run++;
        if (bus.done === 1'b1) begin
          done_seen++;
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending result", cyc);
          end else begin
            e = sb.pop_front();
            check("result_hi", bus.hi, e.hi);
            check("result_lo", bus.lo, e.lo);
            check("done_latency", 32'(cyc - e.acc), 32'(e.lat - 1));
            check("busy_cycles", 32'(busy_run), 32'(e.lat - 1));
          end
          busy_run = 0;
        end
      end
    end
  end

  initial begin : driver
    logic [5:0] fl [6];
    int d0;
    fl[0] = 6'h18; fl[1] = 6'h19; fl[2] = 6'h1A;
    fl[3] = 6'h1B; fl[4] = 6'h11; fl[5] = 6'h13;
    bus.start = 1'b0; bus.funct = '0; bus.operand1 = '0; bus.operand2 = '0;

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_done", {31'b0, bus.done}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    issue(6'h13, 32'h1234_5678, 32'h0);
    issue(6'h18, 32'hFFFF_FFFD, 32'h5);
    issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(6'h1A, 32'hFFFF_FFF9, 32'h2);
    issue(6'h1B, 32'd100, 32'd7);
    issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(6'h1B, 32'h55, 32'h0);
    drain();

    // A second request while busy must be dropped, not queued.
    issue(6'h18, 32'd2, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.funct = 6'h1B; bus.operand1 = 32'd9; bus.operand2 = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain();
    check("ignored_start_hi", bus.hi, 32'h0);
    check("ignored_start_lo", bus.lo, 32'h6);

    // Unsupported funct codes must not touch HI/LO or pulse done.
    bus.start = 1'b1; bus.funct = 6'h20; bus.operand1 = 32'hCAFE_F00D; bus.operand2 = 32'h1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bad_funct_hi", bus.hi, m_hi);
    check("bad_funct_lo", bus.lo, m_lo);

    for (int i = 0; i < 40; i++) begin
      issue(fl[$urandom_range(0, 5)], rand_operand(), rand_operand());
    end
    drain();

    // Reset in the middle of a divide aborts it and clears HI/LO.
    issue(6'h11, 32'hDEAD_BEEF, 32'h0);
    issue(6'h13, 32'h0BAD_F00D, 32'h0);
    drain();
    bus.start = 1'b1; bus.funct = 6'h1A; bus.operand1 = 32'd1000; bus.operand2 = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_busy", {31'b0, bus.busy}, 32'h0);
    check("midreset_hi", bus.hi, 32'h0);
    check("midreset_lo", bus.lo, 32'h0);
    reset_n = 1'b1;
    m_hi = '0; m_lo = '0;
    d0 = done_seen;
    repeat (40) @(posedge clk);
    #1;
    check("midreset_no_done", 32'(done_seen - d0), 32'h0);
    check("midreset_hold_hi", bus.hi, 32'h0);

    issue(6'h19, 32'd7, 32'd6);
    drain();
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
